// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
//   state_e : sequencer states
//   ctrl_t  : bundle of pipeline register controls driven by the sequencer
//   REG_X0  : architectural zero register (never a real dependency)
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        RUN,
        LU_STALL,
        MEM_WAIT,
        FLUSH,
        ERROR
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_hold;
        logic if_id_flush;
        logic combined_stall;
        logic id_ex_hold;
        logic ex_mem_hold;
    } ctrl_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    // Canonical control patterns
    localparam ctrl_t CTRL_RUN = '{pc_write: 1'b1, default: 1'b0};
    localparam ctrl_t CTRL_LU  = '{if_id_hold: 1'b1, combined_stall: 1'b1, default: 1'b0};
    localparam ctrl_t CTRL_BR  = '{pc_write: 1'b1, if_id_flush: 1'b1, combined_stall: 1'b1, default: 1'b0};
    localparam ctrl_t CTRL_FRZ = '{if_id_hold: 1'b1, id_ex_hold: 1'b1, ex_mem_hold: 1'b1, default: 1'b0};

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard classification.
//   Inputs : IF/ID operand fields, ID/EX destination/load info, EX branch
//            outcome, MEM-stage data access handshake.
//   Outputs: hz_lu_o (load-use), hz_br_o (taken branch), hz_mem_o (dmem busy).
// Priority between the hazards is resolved by the sequencer, not here.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       id_valid_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_uses_rs1_i,
    input  logic       id_uses_rs2_i,
    input  logic       ex_valid_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_mem_read_i,
    input  logic       ex_branch_taken_i,
    input  logic       dmem_req_i,
    input  logic       dmem_ready_i,
    output logic       hz_lu_o,
    output logic       hz_br_o,
    output logic       hz_mem_o
);

    logic rs1_dep;
    logic rs2_dep;

    assign rs1_dep = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
    assign rs2_dep = id_uses_rs2_i && (id_rs2_i == ex_rd_i);

    // x0 is hardwired zero, so a load targeting it creates no dependency
    assign hz_lu_o  = id_valid_i && ex_valid_i && ex_mem_read_i &&
                      (ex_rd_i != REG_X0) && (rs1_dep || rs2_dep);
    assign hz_br_o  = ex_branch_taken_i && ex_valid_i;
    assign hz_mem_o = dmem_req_i && !dmem_ready_i;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core.
//   Inputs : clk, reset (async, active-high), ID/EX operand and load info,
//            EX branch outcome, MEM-stage dmem handshake.
//   Outputs: pc_write, if_id_hold, if_id_flush, combined_stall, id_ex_hold,
//            ex_mem_hold (Mealy controls), mem_timeout_err (sticky),
//            stall_cycles (count of cycles with pc_write low).
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_USE_CYCLES = 1,
    parameter int FLUSH_CYCLES    = 1,
    parameter int MEM_TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_valid,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_branch_taken,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_write,
    output logic        if_id_hold,
    output logic        if_id_flush,
    output logic        combined_stall,
    output logic        id_ex_hold,
    output logic        ex_mem_hold,
    output logic        mem_timeout_err,
    output logic [31:0] stall_cycles
);

    localparam logic [3:0]  LU_RELOAD = 4'(LOAD_USE_CYCLES - 1);
    localparam logic [3:0]  FL_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [15:0] TIMEOUT   = 16'(MEM_TIMEOUT);

    logic hz_lu, hz_br, hz_mem;

    state_e      state_q, state_d, eff;
    logic [15:0] wait_q, wait_d;
    logic [3:0]  lu_q, lu_d;
    logic [3:0]  fl_q, fl_d;
    logic [31:0] stall_q;
    ctrl_t       ctrl, ctrl_out;

    hazard_detect u_hd (
        .id_valid_i        (id_valid),
        .id_rs1_i          (id_rs1),
        .id_rs2_i          (id_rs2),
        .id_uses_rs1_i     (id_uses_rs1),
        .id_uses_rs2_i     (id_uses_rs2),
        .ex_valid_i        (ex_valid),
        .ex_rd_i           (ex_rd),
        .ex_mem_read_i     (ex_mem_read),
        .ex_branch_taken_i (ex_branch_taken),
        .dmem_req_i        (dmem_req),
        .dmem_ready_i      (dmem_ready),
        .hz_lu_o           (hz_lu),
        .hz_br_o           (hz_br),
        .hz_mem_o          (hz_mem)
    );

    always_comb begin
        ctrl    = CTRL_RUN;
        state_d = state_q;
        wait_d  = wait_q;
        lu_d    = lu_q;
        fl_d    = fl_q;

        // Once memory releases, behave this very cycle as the state that was
        // interrupted; a pending flush outranks a pending load-use count.
        eff = state_q;
        if (state_q == MEM_WAIT && !hz_mem) begin
            if (fl_q != 4'd0)      eff = FLUSH;
            else if (lu_q != 4'd0) eff = LU_STALL;
            else                   eff = RUN;
        end

        case (eff)
            ERROR: begin
                ctrl = CTRL_FRZ;
            end
            MEM_WAIT: begin
                ctrl = CTRL_FRZ;
                if (wait_q == TIMEOUT) state_d = ERROR;
                else                   wait_d  = wait_q + 16'd1;
            end
            default: begin
                if (hz_mem) begin
                    // Freeze; lu/flush counts kept for the resume
                    ctrl    = CTRL_FRZ;
                    wait_d  = 16'd1;
                    state_d = MEM_WAIT;
                end else if (hz_br) begin
                    // Wrong-path ID instruction is squashed, so any load-use
                    // bubble count is meaningless now
                    ctrl = CTRL_BR;
                    lu_d = 4'd0;
                    fl_d = FL_RELOAD;
                    state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                end else if (eff == FLUSH) begin
                    ctrl    = CTRL_BR;
                    fl_d    = fl_q - 4'd1;
                    state_d = (fl_q == 4'd1) ? RUN : FLUSH;
                end else if (eff == LU_STALL) begin
                    ctrl    = CTRL_LU;
                    lu_d    = lu_q - 4'd1;
                    state_d = (lu_q == 4'd1) ? RUN : LU_STALL;
                end else if (hz_lu) begin
                    ctrl    = CTRL_LU;
                    lu_d    = LU_RELOAD;
                    state_d = (LOAD_USE_CYCLES > 1) ? LU_STALL : RUN;
                end else begin
                    state_d = RUN;
                end
            end
        endcase
    end

    // Outputs are forced to the idle pattern while reset is held
    assign ctrl_out = reset ? CTRL_RUN : ctrl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            wait_q  <= 16'd0;
            lu_q    <= 4'd0;
            fl_q    <= 4'd0;
            stall_q <= 32'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            lu_q    <= lu_d;
            fl_q    <= fl_d;
            if (!ctrl_out.pc_write) stall_q <= stall_q + 32'd1;
        end
    end

    assign pc_write        = ctrl_out.pc_write;
    assign if_id_hold      = ctrl_out.if_id_hold;
    assign if_id_flush     = ctrl_out.if_id_flush;
    assign combined_stall  = ctrl_out.combined_stall;
    assign id_ex_hold      = ctrl_out.id_ex_hold;
    assign ex_mem_hold     = ctrl_out.ex_mem_hold;
    assign mem_timeout_err = (state_q == ERROR);
    assign stall_cycles    = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic       id_valid;
        logic [4:0] id_rs1;
        logic [4:0] id_rs2;
        logic       u1;
        logic       u2;
        logic       ex_valid;
        logic [4:0] ex_rd;
        logic       mem_read;
        logic       br;
        logic       dreq;
        logic       drdy;
    } in_t;

    typedef struct {
        in_t        in;
        logic [6:0] exp;
    } vec_t;

    typedef struct {
        logic [6:0]  outs;
        logic [31:0] stall;
    } sb_t;

    // {pc_write, if_id_hold, if_id_flush, combined_stall, id_ex_hold, ex_mem_hold, mem_timeout_err}
    localparam logic [6:0] O_RUN = 7'b1000000;
    localparam logic [6:0] O_LU  = 7'b0101000;
    localparam logic [6:0] O_BR  = 7'b1011000;
    localparam logic [6:0] O_FRZ = 7'b0100110;
    localparam logic [6:0] O_ERR = 7'b0100111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        id_valid = 0, id_uses_rs1 = 0, id_uses_rs2 = 0;
    logic [4:0]  id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
    logic        ex_valid = 0, ex_mem_read = 0, ex_branch_taken = 0;
    logic        dmem_req = 0, dmem_ready = 0;
    logic        pc_write, if_id_hold, if_id_flush, combined_stall;
    logic        id_ex_hold, ex_mem_hold, mem_timeout_err;
    logic [31:0] stall_cycles;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] exp_stall = 0;
    sb_t         sbq[$];
    vec_t        tbl[$];

    pipeline_hazard_ctrl #(
        .LOAD_USE_CYCLES (2),
        .FLUSH_CYCLES    (3),
        .MEM_TIMEOUT     (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_valid        (ex_valid),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .pc_write        (pc_write),
        .if_id_hold      (if_id_hold),
        .if_id_flush     (if_id_flush),
        .combined_stall  (combined_stall),
        .id_ex_hold      (id_ex_hold),
        .ex_mem_hold     (ex_mem_hold),
        .mem_timeout_err (mem_timeout_err),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {pc_write, if_id_hold, if_id_flush, combined_stall,
                id_ex_hold, ex_mem_hold, mem_timeout_err};
    endfunction

    function automatic vec_t mk(input in_t v, input logic [6:0] e);
        vec_t r;
        r.in  = v;
        r.exp = e;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input in_t v);
        id_valid        = v.id_valid;
        id_rs1          = v.id_rs1;
        id_rs2          = v.id_rs2;
        id_uses_rs1     = v.u1;
        id_uses_rs2     = v.u2;
        ex_valid        = v.ex_valid;
        ex_rd           = v.ex_rd;
        ex_mem_read     = v.mem_read;
        ex_branch_taken = v.br;
        dmem_req        = v.dreq;
        dmem_ready      = v.drdy;
    endtask

    // Drive one cycle, queue its expectation, then compare mid-cycle
    task automatic step(input in_t v, input logic [6:0] e, input string name);
        sb_t s;
        @(negedge clk);
        apply(v);
        s.outs  = e;
        s.stall = exp_stall;
        sbq.push_back(s);
        #2;
        s = sbq.pop_front();
        chk({name, ".ctl"}, {25'd0, outs()}, {25'd0, s.outs});
        chk({name, ".cnt"}, stall_cycles, s.stall);
        if (!e[6]) exp_stall = exp_stall + 32'd1;
    endtask

    initial begin
        in_t idle, lu, lu_x0, lu_nouse2, lu_rs2, lu_noexv, br_lu, br, br_nov;
        in_t membusy, br_membusy, br_memdone;

        idle = '0;
        lu = '0;
        lu.id_valid = 1; lu.id_rs1 = 5'd5; lu.u1 = 1;
        lu.ex_valid = 1; lu.ex_rd = 5'd5; lu.mem_read = 1;
        lu_x0 = lu;      lu_x0.ex_rd = 5'd0; lu_x0.id_rs1 = 5'd0;
        lu_nouse2 = lu;  lu_nouse2.id_rs1 = 5'd1; lu_nouse2.id_rs2 = 5'd5;
        lu_rs2 = lu_nouse2; lu_rs2.u2 = 1;
        lu_noexv = lu;   lu_noexv.ex_valid = 0;
        br_lu = lu;      br_lu.br = 1;
        br = '0;         br.ex_valid = 1; br.br = 1;
        br_nov = '0;     br_nov.br = 1;
        membusy = '0;    membusy.dreq = 1;
        br_membusy = br; br_membusy.dreq = 1;
        br_memdone = br_membusy; br_memdone.drdy = 1;

        // load-use, two bubbles
        tbl.push_back(mk(idle, O_RUN));
        tbl.push_back(mk(lu, O_LU));
        tbl.push_back(mk(lu, O_LU));
        tbl.push_back(mk(idle, O_RUN));
        // no-stall cases
        tbl.push_back(mk(lu_x0, O_RUN));
        tbl.push_back(mk(lu_nouse2, O_RUN));
        tbl.push_back(mk(lu_rs2, O_LU));
        tbl.push_back(mk(idle, O_LU));
        tbl.push_back(mk(lu_noexv, O_RUN));
        // branch with simultaneous load-use: three flush cycles
        tbl.push_back(mk(br_lu, O_BR));
        tbl.push_back(mk(idle, O_BR));
        tbl.push_back(mk(idle, O_BR));
        tbl.push_back(mk(idle, O_RUN));
        tbl.push_back(mk(br_nov, O_RUN));
        // memory stall over a branch
        for (int i = 0; i < 4; i++) tbl.push_back(mk(br_membusy, O_FRZ));
        tbl.push_back(mk(br_memdone, O_BR));
        tbl.push_back(mk(idle, O_BR));
        tbl.push_back(mk(idle, O_BR));
        tbl.push_back(mk(idle, O_RUN));
        // load-use interrupted by memory, then resumed
        tbl.push_back(mk(lu, O_LU));
        tbl.push_back(mk(membusy, O_FRZ));
        tbl.push_back(mk(membusy, O_FRZ));
        tbl.push_back(mk(idle, O_LU));
        tbl.push_back(mk(idle, O_RUN));
        // flush interrupted by memory, then reloaded by a new branch
        tbl.push_back(mk(br, O_BR));
        tbl.push_back(mk(membusy, O_FRZ));
        tbl.push_back(mk(idle, O_BR));
        tbl.push_back(mk(br, O_BR));
        tbl.push_back(mk(idle, O_BR));
        tbl.push_back(mk(idle, O_BR));
        tbl.push_back(mk(idle, O_RUN));
        // branch preempts a load-use stall
        tbl.push_back(mk(lu, O_LU));
        tbl.push_back(mk(br, O_BR));
        tbl.push_back(mk(idle, O_BR));
        tbl.push_back(mk(idle, O_BR));
        tbl.push_back(mk(idle, O_RUN));

        // outputs while reset held
        apply(idle);
        @(negedge clk);
        apply(lu);
        #2;
        chk("reset.ctl", {25'd0, outs()}, {25'd0, O_RUN});
        chk("reset.cnt", stall_cycles, 32'd0);
        @(negedge clk);
        apply(idle);
        reset = 1'b0;

        foreach (tbl[i]) step(tbl[i].in, tbl[i].exp, $sformatf("vec%0d", i));

        // timeout: 9 frozen cycles, then sticky error
        for (int i = 0; i < 9; i++) step(membusy, O_FRZ, $sformatf("to_wait%0d", i));
        for (int i = 0; i < 3; i++) step(idle, O_ERR, $sformatf("to_err%0d", i));

        // asynchronous reset in mid-cycle
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst.ctl", {25'd0, outs()}, {25'd0, O_RUN});
        chk("arst.cnt", stall_cycles, 32'd0);
        exp_stall = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        step(idle, O_RUN, "post_rst");

        // counter wrap
        @(negedge clk);
        force dut.stall_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_q;
        exp_stall = 32'hFFFF_FFFF;
        chk("wrap.pre", stall_cycles, exp_stall);
        step(membusy, O_FRZ, "wrap.stall");
        step(idle, O_RUN, "wrap.post");

        if (sbq.size() != 0) chk("sb.empty", sbq.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage core. It drives the hold, bubble and flush controls of PC, IF/ID, ID/EX and EX/MEM, including the combined_stall bubble input of the decode stage. It detects load-use hazards, freezes the pipe while data memory is busy, and squashes wrong-path instructions after a taken branch. A memory-timeout watchdog and a stall-cycle performance counter are included.

Parameters:
LOAD_USE_CYCLES, 1, number of bubbles inserted per load-use hazard (1..15).
FLUSH_CYCLES, 1, cycles IF/ID is flushed after a redirect (1..15).
MEM_TIMEOUT, 255, dmem wait cycles before fatal error (1..65535).

Ports:
clk  in  1  clock
reset  in  1  reset
id_valid  in  1  valid instruction in IF/ID (fetch_enable_out)
id_rs1  in  5  IF/ID rs1 field
id_rs2  in  5  IF/ID rs2 field
id_uses_rs1  in  1  decoded instruction reads rs1
id_uses_rs2  in  1  decoded instruction reads rs2
ex_valid  in  1  ID/EX holds a valid instruction (decode_enable_out)
ex_rd  in  5  ID/EX destination register
ex_mem_read  in  1  ID/EX instruction is a load
ex_branch_taken  in  1  EX resolves a taken branch/jump
dmem_req  in  1  MEM stage has an outstanding data access
dmem_ready  in  1  data memory completes the access this cycle
pc_write  out  1  PC may update
if_id_hold  out  1  IF/ID keeps its contents
if_id_flush  out  1  IF/ID cleared to invalid
combined_stall  out  1  bubble into ID/EX
id_ex_hold  out  1  ID/EX keeps its contents; no bubble
ex_mem_hold  out  1  EX/MEM and MEM/WB frozen
mem_timeout_err  out  1  sticky fatal error
stall_cycles  out  32  count of cycles with pc_write=0

Behaviour:
- Clock and reset: clk, single clock domain; reset is asynchronous, active-high.
- Reset values: state RUN, counters 0, mem_timeout_err=0, stall_cycles=0.
- Output values while reset is asserted: pc_write=1; all other outputs 0.
- Output timing: state and counters are registered. Control outputs are combinational from state and inputs (Mealy), so hazards act in the same cycle they are detected.
- Hazard terms:
  - hz_mem = dmem_req & ~dmem_ready.
  - hz_br = ex_branch_taken & ex_valid.
  - hz_lu = id_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Priority: hz_mem > hz_br > hz_lu > run.
- RUN state:
  - hz_mem: freeze. pc_write=0, if_id_hold=1, id_ex_hold=1, ex_mem_hold=1, combined_stall=0. wait_cnt<=1; go to MEM_WAIT.
  - hz_br: pc_write=1, if_id_flush=1, combined_stall=1. If FLUSH_CYCLES>1, flush_cnt<=FLUSH_CYCLES-1 and go to FLUSH.
  - hz_lu: pc_write=0, if_id_hold=1, combined_stall=1. If LOAD_USE_CYCLES>1, lu_cnt<=LOAD_USE_CYCLES-1 and go to LU_STALL.
  - Otherwise: pc_write=1; all other controls 0.
- MEM_WAIT state:
  - Freeze outputs while hz_mem holds; wait_cnt increments each cycle.
  - When hz_mem clears: return to RUN and apply RUN evaluation in the same cycle.
  - If wait_cnt==MEM_TIMEOUT while still waiting: go to ERROR.
- LU_STALL state:
  - Same outputs as the hz_lu case; lu_cnt decrements; go to RUN when lu_cnt==1.
  - hz_mem preempts: go to MEM_WAIT, and lu_cnt is retained for the return. After MEM_WAIT ends, resume LU_STALL if lu_cnt!=0.
  - hz_br preempts: take the branch action and discard lu_cnt.
- FLUSH state:
  - pc_write=1, if_id_flush=1, combined_stall=1; flush_cnt decrements; go to RUN at 1.
  - hz_mem preempts: freeze, then resume FLUSH.
  - A new hz_br reloads flush_cnt.
- ERROR state: full freeze, mem_timeout_err=1; held until reset.
- Simultaneous branch and load-use: branch wins; the ID instruction is squashed, so no bubble count is started.
- Branch during a memory stall: not latched. EX is frozen, so the branch is re-evaluated after the stall.
- stall_cycles: increments every cycle pc_write==0, including ERROR; wraps modulo 2^32.
- Reset mid-operation: any state returns to RUN immediately and clears mem_timeout_err.

Decomposition:
- Package pipe_ctrl_pkg: state enum {RUN, LU_STALL, MEM_WAIT, FLUSH, ERROR}; control-bundle struct (pc_write, if_id_hold, if_id_flush, combined_stall, id_ex_hold, ex_mem_hold); constant REG_X0=5'd0.
- Sub-module hazard_detect: purely combinational; produces hz_lu, hz_br, hz_mem.
- FSM and counters stay in the top module.

Test Plan:
1. Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1, LOAD_USE_CYCLES=2. Expect pc_write=0, if_id_hold=1, combined_stall=1 for exactly 2 cycles, then RUN; stall_cycles=2.
2. rd=x0 and no-use cases: ex_rd=0 with a matching rs1, or id_uses_rs2=0 with an rs2 match. Expect no stall; pc_write stays 1.
3. Branch: ex_branch_taken with FLUSH_CYCLES=3. Expect if_id_flush=1 and combined_stall=1 for 3 cycles with pc_write=1. A simultaneous load-use hazard is ignored.
4. Memory stall over a branch: dmem_req=1, dmem_ready=0 for 4 cycles while ex_branch_taken=1. Expect a full freeze (id_ex_hold=1, combined_stall=0). The flush starts in the cycle dmem_ready=1.
5. Timeout: MEM_TIMEOUT=8, dmem_ready held 0. Expect mem_timeout_err=1 after 8 wait cycles, sticky. Asynchronous reset mid-cycle clears it and restores pc_write=1.
6. Counter wrap: preload stall_cycles via force to 32'hFFFF_FFFF, then cause one stall. Expect 0.
